serial_tx_ctrl: RTL and testbench

//  Memory-mapped UART transmit controller for the Serial MMIO window behind Mmu.
//  CPU stores bytes to DATA; a FIFO decouples the CPU from the line rate.
//  A framing FSM shifts bytes out as 8N1 frames on txd. A STATUS register gives

---
 rtl/serial_pkg.sv | 29 ++
 rtl/serial_fifo.sv | 57 +++++
 rtl/serial_tx_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_serial_tx_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit controller: FSM states,
// register offsets, STATUS bit layout and a divisor helper.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 5;

    // A zero divisor would stall the bit timer, so it is promoted to 1.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value == 16'd0) ? 16'd1 : value;
    endfunction

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO with async active-low clear. A simultaneous push and pop
// are both honoured, including when the FIFO is full.
module serial_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     clrn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; the head read is combinational so the old head is
    // captured even when a full-FIFO push overwrites the same slot.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx_ctrl.sv
// Memory-mapped UART transmitter: register file, TX FIFO, bit timer and
// framing FSM. Define SERIAL_TX_PARITY_EN to add an even-parity bit.
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        sel,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        txd,
    output logic        busy
);

    localparam logic [15:0] DEFAULT_DIV = 16'(CLK_HZ / BAUD);
    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;

    logic          wr_data, wr_div, status_rd;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [15:0]   div_reg;
    logic          unused_din;

    tx_state_t     state, state_next;
    logic [7:0]    shifter, shifter_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [1:0]    stop_cnt, stop_cnt_next;
    logic [15:0]   timer, timer_next;
    logic [15:0]   cur_div, cur_div_next;
    logic          txd_next;
    logic          timer_done;

    assign wr_data    = sel & we & (addr == REG_DATA);
    assign wr_div     = sel & we & (addr == REG_DIV);
    assign status_rd  = sel & re & (addr == REG_STATUS);
    assign unused_din = ^din[31:16];
    assign timer_done = (timer == 16'd0);
    assign busy       = (state != ST_IDLE) | ~fifo_empty;

    serial_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .clrn  (clrn),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (din[7:0]),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Divisor register and sticky overflow; a new overflow beats a STATUS-read clear.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            div_reg  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr_div) begin
                div_reg <= clamp_div(din[15:0]);
            end
            if (wr_data & fifo_full & ~fifo_pop) begin
                overflow <= 1'b1;
            end else if (status_rd) begin
                overflow <= 1'b0;
            end
        end
    end

    // Read mux; purely combinational with no side effects of its own.
    always_comb begin
        dout = '0;
        if (sel & re) begin
            case (addr)
                REG_STATUS: begin
                    dout[STAT_EMPTY] = fifo_empty;
                    dout[STAT_FULL]  = fifo_full;
                    dout[STAT_BUSY]  = busy;
                    dout[STAT_OVF]   = overflow;
                    dout[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
                end
                REG_DIV: dout = {16'b0, div_reg};
                default: dout = '0;
            endcase
        end
    end

    // Framing FSM state, shifter, bit timer and registered line output.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state    <= ST_IDLE;
            shifter  <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
            timer    <= '0;
            cur_div  <= DEFAULT_DIV;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            shifter  <= shifter_next;
            bit_idx  <= bit_idx_next;
            stop_cnt <= stop_cnt_next;
            timer    <= timer_next;
            cur_div  <= cur_div_next;
            txd      <= txd_next;
        end
    end

    // Next-state logic; txd_next is the level of the bit the FSM is entering.
    always_comb begin
        state_next    = state;
        shifter_next  = shifter;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;
        timer_next    = timer_done ? timer : timer - 16'd1;
        cur_div_next  = cur_div;
        txd_next      = txd;
        fifo_pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                txd_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shifter_next = fifo_head;
                    cur_div_next = div_reg;
                    timer_next   = div_reg - 16'd1;
                    state_next   = ST_START;
                    txd_next     = 1'b0;
                end
            end
            ST_START: begin
                if (timer_done) begin
                    state_next   = ST_DATA;
                    bit_idx_next = 3'd0;
                    timer_next   = cur_div - 16'd1;
                    txd_next     = shifter[0];
                end
            end
            ST_DATA: begin
                if (timer_done) begin
                    timer_next = cur_div - 16'd1;
                    if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_next = ST_PARITY;
                        txd_next   = ^shifter;
`else
                        state_next    = ST_STOP;
                        stop_cnt_next = 2'd0;
                        txd_next      = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        txd_next     = shifter[bit_idx + 3'd1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (timer_done) begin
                    state_next    = ST_STOP;
                    stop_cnt_next = 2'd0;
                    timer_next    = cur_div - 16'd1;
                    txd_next      = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (timer_done) begin
                    if (stop_cnt == 2'(STOP_BITS - 1)) begin
                        if (!fifo_empty) begin
                            fifo_pop     = 1'b1;
                            shifter_next = fifo_head;
                            cur_div_next = div_reg;
                            timer_next   = div_reg - 16'd1;
                            state_next   = ST_START;
                            txd_next     = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        stop_cnt_next = stop_cnt + 2'd1;
                        timer_next    = cur_div - 16'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Self-checking bench for serial_tx_ctrl: a register-access vector table
// followed by hand-written frame, FIFO, divisor and reset sequences.
module tb_serial_tx_ctrl;

    logic        clock;
    logic        clrn;
    logic        sel;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        txd;
    logic        busy;

    int vectors;
    int miscompares;

    typedef struct {
        string       name;
        logic        is_write;
        logic        rd_en;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] expect_val;
    } vec_t;

    vec_t vecs[12];

    serial_tx_ctrl dut (
        .clock (clock),
        .clrn  (clrn),
        .sel   (sel),
        .we    (we),
        .re    (re),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .txd   (txd),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clock);
        sel = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clock);
        #1;
        sel = 1'b0; we = 1'b0; din = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clock);
        sel = 1'b1; re = 1'b1; addr = a;
        #1;
        d = dout;
        @(posedge clock);
        #1;
        sel = 1'b0; re = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] expected);
        logic [31:0] d;
        bus_read(a, d);
        check_output(name, d, expected);
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.is_write) begin
            bus_write(v.addr, v.data);
        end else if (v.rd_en) begin
            read_check(v.name, v.addr, v.expect_val);
        end else begin
            @(negedge clock);
            sel = 1'b1; re = 1'b0; addr = v.addr;
            #1;
            check_output(v.name, dout, v.expect_val);
            sel = 1'b0;
        end
    endtask

    // Wait (bounded, negedge-sampled) until txd reaches the given level.
    task automatic wait_txd(input logic level, input int limit, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (txd === level) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check_output(name, {31'b0, found}, 32'd1);
    endtask

    // Check one full frame, every clock of every bit. On return the bench sits
    // at the negedge of the first clock after the final stop bit.
    task automatic check_frame(input logic [7:0] b, input int div, input logic immediate,
                               input int limit, input string name);
        logic bits [12];
        int   n;
        logic act;
        if (!immediate) @(negedge clock);
        wait_txd(1'b0, immediate ? 1 : limit, {name, "_start"});
        check_output({name, "_busy"}, {31'b0, busy}, 32'd1);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
        n = 9;
`ifdef SERIAL_TX_PARITY_EN
        bits[n] = ^b;
        n++;
`endif
        bits[n] = 1'b1;
        n++;
        for (int k = 0; k < n; k++) begin
            act = bits[k];
            for (int c = 0; c < div; c++) begin
                if (txd !== bits[k]) act = txd;
                @(negedge clock);
            end
            check_output($sformatf("%s_bit%0d", name, k), {31'b0, act}, {31'b0, bits[k]});
        end
    endtask

    initial begin
        logic [31:0] rd;
        vectors     = 0;
        miscompares = 0;
        sel = 1'b0; we = 1'b0; re = 1'b0; addr = '0; din = '0;
        clrn = 1'b0;

        vecs[0]  = '{"status_reset",   1'b0, 1'b1, 2'd1, 32'h0,         32'h1};
        vecs[1]  = '{"div_reset",      1'b0, 1'b1, 2'd2, 32'h0,         32'd434};
        vecs[2]  = '{"data_read_zero", 1'b0, 1'b1, 2'd0, 32'h0,         32'h0};
        vecs[3]  = '{"reserved_zero",  1'b0, 1'b1, 2'd3, 32'h0,         32'h0};
        vecs[4]  = '{"no_re_zero",     1'b0, 1'b0, 2'd2, 32'h0,         32'h0};
        vecs[5]  = '{"wr_div0",        1'b1, 1'b0, 2'd2, 32'h0,         32'h0};
        vecs[6]  = '{"div0_as_1",      1'b0, 1'b1, 2'd2, 32'h0,         32'h1};
        vecs[7]  = '{"wr_div_wide",    1'b1, 1'b0, 2'd2, 32'hABCD_2345, 32'h0};
        vecs[8]  = '{"div_low16",      1'b0, 1'b1, 2'd2, 32'h0,         32'h2345};
        vecs[9]  = '{"wr_div4",        1'b1, 1'b0, 2'd2, 32'd4,         32'h0};
        vecs[10] = '{"div4",           1'b0, 1'b1, 2'd2, 32'h0,         32'd4};
        vecs[11] = '{"status_idle",    1'b0, 1'b1, 2'd1, 32'h0,         32'h1};

        repeat (3) @(negedge clock);
        check_output("reset_txd", {31'b0, txd}, 32'd1);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        clrn = 1'b1;

        for (int i = 0; i < 12; i++) apply_stimulus(vecs[i]);

        // Single 0x55 frame at DIV=4; busy drops once the stop bit ends.
        bus_write(2'd0, 32'h55);
        check_output("t1_busy_queued", {31'b0, busy}, 32'd1);
        check_frame(8'h55, 4, 1'b0, 20, "t1");
        check_output("t1_busy_after", {31'b0, busy}, 32'd0);
        check_output("t1_txd_idle", {31'b0, txd}, 32'd1);

        // Back-to-back frames with no idle gap.
        bus_write(2'd0, 32'h41);
        bus_write(2'd0, 32'h42);
        check_frame(8'h41, 4, 1'b0, 20, "t2a");
        check_frame(8'h42, 4, 1'b1, 1, "t2b");
        check_output("t2_busy_after", {31'b0, busy}, 32'd0);

        // Divisor change mid-frame applies only from the next frame.
        bus_write(2'd2, 32'd0);
        read_check("t4_div_is_1", 2'd2, 32'd1);
        fork
            begin
                bus_write(2'd0, 32'h3C);
                bus_write(2'd0, 32'hC3);
                bus_write(2'd2, 32'd8);
            end
            begin
                check_frame(8'h3C, 1, 1'b0, 20, "t4a");
                check_frame(8'hC3, 8, 1'b1, 1, "t4b");
            end
        join
        check_output("t4_busy_after", {31'b0, busy}, 32'd0);
        read_check("t4_div_is_8", 2'd2, 32'd8);

        // Fill the FIFO behind a slow frame, overflow, clear, then drain in order.
        bus_write(2'd2, 32'd1000);
        bus_write(2'd0, 32'hFF);
        for (int i = 0; i < 16; i++) bus_write(2'd0, 32'h10 + i);
        bus_write(2'd0, 32'hEE);
        read_check("t3_status_ovf", 2'd1, 32'h0000_100E);
        read_check("t3_status_clr", 2'd1, 32'h0000_1006);
        bus_write(2'd2, 32'd4);
        wait_txd(1'b1, 2000, "t3_slow_start_end");
        check_frame(8'h10, 4, 1'b0, 12000, "t3_b0");
        for (int i = 1; i < 16; i++) begin
            check_frame(8'(8'h10 + i), 4, 1'b1, 1, $sformatf("t3_b%0d", i));
        end
        check_output("t3_busy_after", {31'b0, busy}, 32'd0);
        read_check("t3_status_end", 2'd1, 32'h1);

        // Asynchronous reset in the middle of the data bits.
        bus_write(2'd0, 32'hF0);
        wait_txd(1'b0, 20, "t5_start");
        repeat (5) @(negedge clock);
        check_output("t5_pre_reset_txd", {31'b0, txd}, 32'd0);
        #2;
        clrn = 1'b0;
        #1;
        check_output("t5_txd_async", {31'b0, txd}, 32'd1);
        check_output("t5_busy", {31'b0, busy}, 32'd0);
        sel = 1'b1; re = 1'b1; addr = 2'd1;
        #1;
        check_output("t5_status", dout, 32'h1);
        addr = 2'd2;
        #1;
        check_output("t5_div", dout, 32'd434);
        sel = 1'b0; re = 1'b0;
        @(negedge clock);
        clrn = 1'b1;

`ifdef SERIAL_TX_PARITY_EN
        // Parity frame: 0x07 has odd weight, so the parity bit is 1.
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h07);
        check_frame(8'h07, 2, 1'b0, 20, "t6");
        check_output("t6_busy_after", {31'b0, busy}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
